bin2bcd_seq_ctrl: RTL and testbench
===================================

Name: bin2bcd_seq_ctrl

Overview:
- Sequential binary-to-BCD converter and controller. It runs the shift-and-add-3 (double-dabble) algorithm one bit per two clocks.
- It replaces the fixed combinational "compare against 9 and subtract 10" digit split. This lets wider binary values (switch inputs, counter values) drive the per-digit 7-segment decoders.
- Start/busy/done handshake. The result register holds steady between conversions so the display never shows intermediate digits.

Parameters:
- WIDTH, 8: width of the binary input.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1; an elaboration-time check fails otherwise.

Ports:
- Clock, input, 1: single system clock, rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- start, input, 1: request a conversion; sampled only in IDLE.
- bin, input, WIDTH: binary value; captured on the edge that accepts start.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when bcd is updated.
- bcd, output, 4*DIGITS: result; digit i is at bits [4i+3:4i], digit 0 is the ones digit.

Behaviour:
- Reset (async assert, any state): state=IDLE, busy=0, done=0, bcd=0, scratch=0, count=0. Reset during a conversion aborts it and produces no done pulse.
- Scratch register: 4*DIGITS+WIDTH bits, laid out as {digits, shift}. count: $clog2(WIDTH+1) bits.
- IDLE:
  - If start=1: scratch <= {0, bin}, count <= WIDTH, next state ADJUST.
  - Otherwise remain in IDLE.
- ADJUST: every 4-bit digit field in the upper part of scratch that is >=5 gets +3, all digits in parallel, no carry between digits. Next state SHIFT.
- SHIFT: scratch <= scratch << 1, zero fill; count <= count-1.
  - If count==1 before the decrement: next state DONE.
  - Otherwise: next state ADJUST.
- DONE: bcd <= upper 4*DIGITS bits of scratch; done=1 for this cycle only; next state IDLE.
- Latency: with the start-accepting edge as edge 0, done is high after edge 2*WIDTH+1 (17 cycles for WIDTH=8). A new start is accepted on the edge after done.
- While busy, start is ignored, and changes on bin are ignored.
- bcd changes only on entry to DONE. It holds its value through IDLE and through the next conversion.
- bin=0 gives all-zero digits. The maximum input 2^WIDTH-1 must yield a correct result without any digit exceeding 9.
- busy is a combinational decode of state (state != IDLE). done is a registered state decode, with no glitch at the reset release edge.
- State encoding: 2-bit binary, IDLE=0, ADJUST=1, SHIFT=2, DONE=3.

Decomposition:
- Shared package/include:
  - State encoding constants (ST_IDLE, ST_ADJUST, ST_SHIFT, ST_DONE).
  - The BCD digit width constant (4).
  - Default WIDTH/DIGITS.
- One natural sub-module: bcd_digit_adj3, a 4-bit in/out block that outputs the input +3 when the input >=5 and otherwise passes it through. It is instantiated DIGITS times by generate in the ADJUST path.
- The downstream 7-segment decoders are not part of this block.

Test Plan:
- Reset, then start with bin=8'd15 -> after 17 cycles done pulses once; bcd=12'h015; busy high for exactly 17 cycles.
- bin=8'd255 -> bcd=12'h255. bin=8'd0 -> bcd=12'h000. bin=8'd99 -> bcd=12'h099. bin=8'd100 -> bcd=12'h100. Sweep all 256 values against a reference model.
- While busy, toggle start and change bin (200 -> 37 mid-conversion) -> exactly one done pulse; result 12'h200; the second start is not queued.
- Back-to-back: start held high continuously with bin=42 -> done every 18 cycles; bcd=12'h042 each time.
- Assert Reset at cycle 5 of a conversion of bin=123 -> busy=0, done=0, bcd=0 immediately. A later start with bin=123 gives 12'h123.
- Check bcd stability: during a conversion of 77 following a conversion of 250, bcd stays 12'h250 until the done edge, then becomes 12'h077.

Source files
------------

// File: rtl/bin2bcd_seq_ctrl_pkg.sv
// Shared constants for the sequential binary-to-BCD converter: FSM encoding,
// digit width, default sizing and the digit-count sanity check.
package bin2bcd_seq_ctrl_pkg;

    localparam int BCD_W      = 4;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADJUST = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_fit(input int width, input int digits);
        longint p10;
        longint max_bin;
        if (digits > 18 || width > 62) return (digits > 18);
        p10 = 1;
        for (int i = 0; i < digits; i++) p10 = p10 * 10;
        max_bin = (longint'(1) << width) - 1;
        return p10 > max_bin;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// Start/busy/done handshake plus operand and result bus for the converter.
interface bin2bcd_if
    import bin2bcd_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
);
    logic                      start;
    logic [WIDTH-1:0]          bin;
    logic                      busy;
    logic                      done;
    logic [BCD_W*DIGITS-1:0]   bcd;

    modport master (output start, output bin, input busy, input done, input bcd);
    modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_seq_ctrl_adj3.sv
// One double-dabble digit correction: add 3 when the digit is 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj3
    import bin2bcd_seq_ctrl_pkg::*;
(
    input  logic [BCD_W-1:0] din,
    output logic [BCD_W-1:0] dout
);
    assign dout = (din >= BCD_W'(5)) ? din + BCD_W'(3) : din;
endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Sequential shift-and-add-3 converter: one input bit per ADJUST/SHIFT pair,
// result register updated only when a conversion completes.
module bin2bcd_seq_ctrl
    import bin2bcd_seq_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
)(
    input  logic      clk,
    input  logic      rst,
    bin2bcd_if.slave  bus
);
    localparam int DW    = BCD_W * DIGITS;
    localparam int SCR_W = DW + WIDTH;
    localparam int CW    = $clog2(WIDTH + 1);

    if (!digits_fit(WIDTH, DIGITS)) begin : g_param_chk
        $error("bin2bcd_seq_ctrl: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    state_e              state_q, state_d;
    logic [SCR_W-1:0]    scratch_q, scratch_d;
    logic [CW-1:0]       count_q, count_d;
    logic [DW-1:0]       bcd_q, bcd_d;
    logic                done_q, done_d;

    logic [DIGITS-1:0][BCD_W-1:0] dig_adj;
    logic [SCR_W-1:0]             adj_scratch;

    // Digit fields sit above the shift field; they are corrected independently.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .din  (scratch_q[WIDTH + BCD_W*i +: BCD_W]),
            .dout (dig_adj[i])
        );
    end

    assign adj_scratch = {dig_adj, scratch_q[WIDTH-1:0]};

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    scratch_d = {{DW{1'b0}}, bus.bin};
                    count_d   = CW'(WIDTH);
                    state_d   = ST_ADJUST;
                end
            end
            ST_ADJUST: begin
                scratch_d = adj_scratch;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                scratch_d = scratch_q << 1;
                count_d   = count_q - CW'(1);
                state_d   = (count_q == CW'(1)) ? ST_DONE : ST_ADJUST;
            end
            ST_DONE: begin
                // Result and done pulse launch together, so bcd never shows partial digits.
                bcd_d   = scratch_q[SCR_W-1 -: DW];
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq_ctrl.sv
// Directed bench for bin2bcd_seq_ctrl: latency, handshake, reset abort,
// result stability and a full 8-bit sweep against a divide/modulo model.
module tb_bin2bcd_seq_ctrl;
    import bin2bcd_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    bin2bcd_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bin2bcd_seq_ctrl #(.WIDTH(8), .DIGITS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Start one conversion; returns result, edges until done, busy-high cycles.
    task automatic run_conv(input logic [7:0] v, output logic [11:0] res,
                            output int lat, output int bcyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat  = 0;
        bcyc = bus.busy ? 1 : 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.busy) bcyc++;
        end
        res = bus.bcd;
    endtask

    logic [11:0] res;
    int          lat, bcyc, pulses, gap;
    bit          stable;

    initial begin
        bus.start = 1'b0;
        bus.bin   = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_bcd",  bus.bcd,  0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rel_done", bus.done, 0);

        // Basic latency / single pulse
        run_conv(8'd15, res, lat, bcyc);
        chk("b15_res",  res,  12'h015);
        chk("b15_lat",  lat,  17);
        chk("b15_busy", bcyc, 17);
        @(posedge clk);
        #1;
        chk("b15_pulse1", bus.done, 0);
        chk("b15_hold",   bus.bcd,  12'h015);

        run_conv(8'd255, res, lat, bcyc); chk("b255", res, 12'h255);
        run_conv(8'd0,   res, lat, bcyc); chk("b0",   res, 12'h000);
        run_conv(8'd99,  res, lat, bcyc); chk("b99",  res, 12'h099);
        run_conv(8'd100, res, lat, bcyc); chk("b100", res, 12'h100);

        // Start and bin changes while busy must be ignored, not queued
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 45; c++) begin
            if (c >= 3 && c <= 10) begin
                bus.start = c[0];
                bus.bin   = 8'd37;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                chk("mid_res", bus.bcd, 12'h200);
            end
        end
        chk("mid_pulses", pulses, 1);
        chk("mid_idle",   bus.busy, 0);
        chk("mid_hold",   bus.bcd, 12'h200);

        // Start held high: done every 18 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd42;
        gap = 0;
        while (!bus.done && gap < 100) begin
            @(posedge clk);
            #1;
            gap++;
        end
        chk("b2b_first", bus.bcd, 12'h042);
        for (int k = 0; k < 2; k++) begin
            gap = 0;
            do begin
                @(posedge clk);
                #1;
                gap++;
            end while (!bus.done && gap < 100);
            chk("b2b_gap", gap, 18);
            chk("b2b_res", bus.bcd, 12'h042);
        end
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Reset mid-conversion aborts with no done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd123;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_bcd",  bus.bcd,  0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        chk("abort_nopulse", pulses, 0);
        run_conv(8'd123, res, lat, bcyc);
        chk("b123", res, 12'h123);

        // Result must hold the previous value until the done edge
        run_conv(8'd250, res, lat, bcyc);
        chk("b250", res, 12'h250);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd77;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        stable = 1'b1;
        gap = 0;
        while (!bus.done && gap < 100) begin
            if (bus.bcd !== 12'h250) stable = 1'b0;
            @(posedge clk);
            #1;
            gap++;
        end
        chk("stab_hold", stable, 1);
        chk("stab_new",  bus.bcd, 12'h077);

        // Full sweep against the reference model
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), res, lat, bcyc);
            chk($sformatf("sweep_%0d", v), res, ref_bcd(v));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
